// File: rtl/keypad_cursor_ctrl.sv
// rtl/keypad_cursor_ctrl.sv - keypad direction codes to bounded 2-D cursor with first-press and auto-repeat
//
// Purpose: turns held keypad directions into cursor steps. A new press steps
// once at once; a held key steps again after FIRST_DLY ticks, then every
// RPT_DLY ticks. Each step is one clock in S_STEP.
//
// Ports:
//   clk      in   1   rising-edge clock
//   resetn   in   1   asynchronous active-low reset
//   vir      in   2   x command: 10 = x-1, 01 = x+1, 00/11 = none
//   hor      in   2   y command: 10 = y-1, 01 = y+1, 00/11 = none
//   tick     in   1   one-cycle timebase strobe for the hold delays
//   home     in   1   synchronous return to INIT_X/INIT_Y, beats everything else
//   pos_x    out  PW  cursor x
//   pos_y    out  PW  cursor y
//   moved    out  1   one-cycle pulse, position changed
//   blocked  out  1   one-cycle pulse, a requested step was clipped
//   busy     out  1   high whenever the scheduler is not idle
//
// Build option: define CURSOR_WRAP_EN to wrap at the edges instead of
// saturating (blocked then stays 0).

module keypad_cursor_ctrl #(
    parameter int PW        = 3,
    parameter int X_MAX     = 7,
    parameter int Y_MAX     = 7,
    parameter int INIT_X    = 0,
    parameter int INIT_Y    = 0,
    parameter int FIRST_DLY = 8,
    parameter int RPT_DLY   = 2,
    parameter int CW        = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [1:0]    vir,
    input  logic [1:0]    hor,
    input  logic          tick,
    input  logic          home,
    output logic [PW-1:0] pos_x,
    output logic [PW-1:0] pos_y,
    output logic          moved,
    output logic          blocked,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STEP   = 2'd1,
        S_FIRST  = 2'd2,
        S_REPEAT = 2'd3
    } state_t;

    localparam logic [PW-1:0] X_MAX_V   = PW'(X_MAX);
    localparam logic [PW-1:0] Y_MAX_V   = PW'(Y_MAX);
    localparam logic [PW-1:0] INIT_X_V  = PW'(INIT_X);
    localparam logic [PW-1:0] INIT_Y_V  = PW'(INIT_Y);
    localparam logic [CW-1:0] FIRST_LIM = CW'(FIRST_DLY - 1);
    localparam logic [CW-1:0] RPT_LIM   = CW'(RPT_DLY - 1);

    state_t        state_q,   state_d;
    logic [PW-1:0] pos_x_q,   pos_x_d;
    logic [PW-1:0] pos_y_q,   pos_y_d;
    logic          moved_q,   moved_d;
    logic          blocked_q, blocked_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic [3:0]    dir_q,     dir_d;
    logic          rpt_q,     rpt_d;

    logic [1:0]    vir_f, hor_f;
    logic [3:0]    dir;
    logic [PW-1:0] nx, ny;
    logic          clip_x, clip_y;
    logic [CW-1:0] lim;

    // 11 on an axis means both keys pressed; treat it as no motion on that axis.
    assign vir_f = (vir == 2'b11) ? 2'b00 : vir;
    assign hor_f = (hor == 2'b11) ? 2'b00 : hor;
    assign dir   = {vir_f, hor_f};

    // One-axis step: returns {clipped, new_position}.
    function automatic logic [PW:0] axis_step(
        input logic [PW-1:0] p,
        input logic [1:0]    c,
        input logic [PW-1:0] maxv
    );
        logic [PW:0] r;
        r = {1'b0, p};
        case (c)
            2'b01: begin
                if (p == maxv) begin
`ifdef CURSOR_WRAP_EN
                    r = {1'b0, {PW{1'b0}}};
`else
                    r = {1'b1, p};
`endif
                end else begin
                    r = {1'b0, p + 1'b1};
                end
            end
            2'b10: begin
                if (p == '0) begin
`ifdef CURSOR_WRAP_EN
                    r = {1'b0, maxv};
`else
                    r = {1'b1, p};
`endif
                end else begin
                    r = {1'b0, p - 1'b1};
                end
            end
            default: r = {1'b0, p};
        endcase
        return r;
    endfunction

    assign {clip_x, nx} = axis_step(pos_x_q, dir_q[3:2], X_MAX_V);
    assign {clip_y, ny} = axis_step(pos_y_q, dir_q[1:0], Y_MAX_V);
    assign lim = (state_q == S_FIRST) ? FIRST_LIM : RPT_LIM;

    always_comb begin
        state_d   = state_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        moved_d   = 1'b0;
        blocked_d = 1'b0;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        rpt_d     = rpt_q;

        if (home) begin
            pos_x_d = INIT_X_V;
            pos_y_d = INIT_Y_V;
            moved_d = (pos_x_q != INIT_X_V) || (pos_y_q != INIT_Y_V);
            state_d = S_IDLE;
            cnt_d   = '0;
            rpt_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (dir != 4'b0) begin
                        dir_d   = dir;
                        rpt_d   = 1'b0;
                        state_d = S_STEP;
                    end
                end
                S_STEP: begin
                    pos_x_d   = nx;
                    pos_y_d   = ny;
`ifdef CURSOR_WRAP_EN
                    moved_d   = (dir_q != 4'b0);
`else
                    moved_d   = (nx != pos_x_q) || (ny != pos_y_q);
`endif
                    blocked_d = clip_x | clip_y;
                    state_d   = rpt_q ? S_REPEAT : S_FIRST;
                    cnt_d     = '0;
                    rpt_d     = 1'b1;
                end
                S_FIRST, S_REPEAT: begin
                    if (dir == 4'b0) begin
                        state_d = S_IDLE;
                    end else if (dir != dir_q) begin
                        // A new direction acts like a fresh press; any tick this cycle is dropped.
                        dir_d   = dir;
                        rpt_d   = 1'b0;
                        state_d = S_STEP;
                    end else if (tick) begin
                        if (cnt_q == lim) begin
                            state_d = S_STEP;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            pos_x_q   <= INIT_X_V;
            pos_y_q   <= INIT_Y_V;
            moved_q   <= 1'b0;
            blocked_q <= 1'b0;
            cnt_q     <= '0;
            dir_q     <= 4'b0;
            rpt_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            moved_q   <= moved_d;
            blocked_q <= blocked_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            rpt_q     <= rpt_d;
        end
    end

    assign pos_x   = pos_x_q;
    assign pos_y   = pos_y_q;
    assign moved   = moved_q;
    assign blocked = blocked_q;
    assign busy    = (state_q != S_IDLE);

endmodule
